// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;

endpackage

// File: rtl/shift_stage.sv
// One combinational shift step by an arbitrary distance in any of the four modes.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   distance,
    input  logic [1:0]       op,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);

    logic [SHW:0]       rot_s;
    logic [WIDTH-1:0]   sign_mask_s;

    // Select the shifted word for the requested mode
    always_comb begin
        rot_s       = (SHW+1)'(WIDTH) - {1'b0, distance};
        sign_mask_s = ~({WIDTH{1'b1}} >> distance);
        shifted     = data;
        case (op)
            OP_SLL: shifted = data << distance;
            OP_SRL: shifted = data >> distance;
            OP_SRA: begin
                if (fill) begin
                    shifted = (data >> distance) | sign_mask_s;
                end else begin
                    shifted = data >> distance;
                end
            end
            OP_ROL: shifted = (data << distance) | (data >> rot_s);
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Iterative multi-mode shifter: one shift-amount bit per clock, valid/ready on both sides.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_DONE = 1'b0,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       state_r;
    logic [SHW-1:0]   stage_r;
    logic [WIDTH-1:0] work_r;
    logic [SHW-1:0]   shamt_r;
    logic [1:0]       op_r;
    logic             fill_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;

    logic [SHW-1:0]   distance_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] work_next_s;
    logic [SHW-1:0]   shamt_hi_s;
    logic             last_s;

    shift_stage #(.WIDTH(WIDTH)) u_stage (
        .data     (work_r),
        .distance (distance_s),
        .op       (op_r),
        .fill     (fill_r),
        .shifted  (shifted_s)
    );

    // Per-stage shift step and exit decision
    always_comb begin
        distance_s  = SHW'(1'b1) << stage_r;
        shamt_hi_s  = (shamt_r >> stage_r) >> 1;
        work_next_s = work_r;
        last_s      = 1'b0;
        if (shamt_r[stage_r]) begin
            work_next_s = shifted_s;
        end else begin
            work_next_s = work_r;
        end
        // Early exit once no higher shift-amount bits remain to be applied
        if (stage_r == SHW'(SHW - 1)) begin
            last_s = 1'b1;
        end else if (EARLY_DONE && (shamt_hi_s == '0)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // FSM, operand capture, iteration and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= S_IDLE;
            stage_r     <= '0;
            work_r      <= '0;
            shamt_r     <= '0;
            op_r        <= 2'b00;
            fill_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        work_r     <= in_data;
                        shamt_r    <= in_shamt;
                        op_r       <= in_op;
                        fill_r     <= in_data[WIDTH-1];
                        stage_r    <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    work_r  <= work_next_s;
                    stage_r <= stage_r + SHW'(1'b1);
                    if (last_s) begin
                        out_data_r  <= work_next_s;
                        out_valid_r <= 1'b1;
                        state_r     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter with fixed-latency and early-done instances.
module tb_seq_shifter;

    logic        clock = 1'b0;
    logic        reset;
    logic        v0, v1;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_ready;
    logic        i0_ready, i1_ready, o0_valid, o1_valid;
    logic [31:0] o0_data, o1_data;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    seq_shifter #(.WIDTH(32), .EARLY_DONE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .in_valid(v0), .in_ready(i0_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(o0_valid), .out_ready(out_ready), .out_data(o0_data)
    );

    seq_shifter #(.WIDTH(32), .EARLY_DONE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .in_valid(v1), .in_ready(i1_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(o1_valid), .out_ready(out_ready), .out_data(o1_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one operation, then scramble the inputs to show they are ignored mid-operation
    task automatic run(input bit sel, input logic [31:0] d, input logic [4:0] sh,
                       input logic [1:0] op, input logic [31:0] exp,
                       input int exp_lat, input int hold);
        int  lat;
        bit  rdy_seen;
        in_data   = d;
        in_shamt  = sh;
        in_op     = op;
        out_ready = 1'b0;
        if (sel) v1 = 1'b1; else v0 = 1'b1;
        step();
        v0 = 1'b0;
        v1 = 1'b0;
        in_data  = ~d;
        in_op    = op ^ 2'b11;
        in_shamt = ~sh;
        lat      = 0;
        rdy_seen = 1'b0;
        while (!(sel ? o1_valid : o0_valid) && lat < 20) begin
            if (sel ? i1_ready : i0_ready) rdy_seen = 1'b1;
            step();
            lat++;
        end
        chk("busy_in_ready", {31'd0, rdy_seen}, 32'd0);
        chk("latency", lat, exp_lat);
        chk("result", sel ? o1_data : o0_data, exp);
        for (int k = 0; k < hold; k++) begin
            step();
            chk("hold_valid", {31'd0, sel ? o1_valid : o0_valid}, 32'd1);
            chk("hold_data", sel ? o1_data : o0_data, exp);
            chk("hold_in_ready", {31'd0, sel ? i1_ready : i0_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("consumed_valid", {31'd0, sel ? o1_valid : o0_valid}, 32'd0);
        chk("idle_in_ready", {31'd0, sel ? i1_ready : i0_ready}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        v0        = 1'b0;
        v1        = 1'b0;
        in_data   = 32'd0;
        in_shamt  = 5'd0;
        in_op     = 2'b00;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready0", {31'd0, i0_ready}, 32'd1);
        chk("rst_out_valid0", {31'd0, o0_valid}, 32'd0);
        chk("rst_out_data0", o0_data, 32'd0);
        chk("rst_in_ready1", {31'd0, i1_ready}, 32'd1);
        reset = 1'b0;
        step();

        run(1'b0, 32'h0000FFFF, 5'd16, 2'b00, 32'hFFFF0000, 5, 0);
        run(1'b0, 32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF, 5, 0);
        run(1'b0, 32'h80000000, 5'd31, 2'b01, 32'h00000001, 5, 0);
        run(1'b0, 32'h80000001, 5'd4,  2'b11, 32'h00000018, 5, 3);
        run(1'b0, 32'h12345678, 5'd8,  2'b11, 32'h34567812, 5, 0);
        run(1'b0, 32'h40000000, 5'd2,  2'b10, 32'h10000000, 5, 0);
        run(1'b0, 32'hF0000000, 5'd4,  2'b01, 32'h0F000000, 5, 0);
        run(1'b0, 32'hCAFEBABE, 5'd0,  2'b00, 32'hCAFEBABE, 5, 0);

        run(1'b1, 32'h00000003, 5'd1,  2'b00, 32'h00000006, 1, 0);
        run(1'b1, 32'hA5A5A5A5, 5'd0,  2'b10, 32'hA5A5A5A5, 1, 0);
        run(1'b1, 32'hABCD0000, 5'd16, 2'b01, 32'h0000ABCD, 5, 0);
        run(1'b1, 32'h80000000, 5'd3,  2'b10, 32'hF0000000, 2, 0);

        // Abort during stage 2: accept, two more edges, then reset
        in_data  = 32'h0000FFFF;
        in_shamt = 5'd31;
        in_op    = 2'b00;
        v0       = 1'b1;
        step();
        v0 = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_out_valid", {31'd0, o0_valid}, 32'd0);
        chk("abort_out_data", o0_data, 32'd0);
        chk("abort_in_ready", {31'd0, i0_ready}, 32'd1);
        run(1'b0, 32'h00000001, 5'd31, 2'b00, 32'h80000000, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised, iterative multi-mode shifter for the processor datapath. It generalises the fixed shift-by-16 block to any power-of-two width, any shift amount and four shift modes. It resolves one shift-amount bit per clock: stage k shifts by 2^k. Valid/ready handshakes on both sides let the ALU issue an operation and stall until the result is consumed.

## Interface
Parameters:
- WIDTH, 32, data width; must be a power of two, at least 2.
- EARLY_DONE, 0, when 1, finish as soon as no set shift-amount bits remain.
- SHW (derived), $clog2(WIDTH), shift-amount width; not user-set.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0..WIDTH-1.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result; stable while out_valid is high.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0. Internal operand, shamt, op and stage counter all reset to 0.
- IDLE: when in_valid is high at an edge, capture in_data, in_shamt and in_op. Set stage=0 and go to SHIFT.
- SHIFT: on each edge, if shamt[stage] is set, shift the working register by 2^stage using the captured op. Then increment stage.
  - Leave SHIFT after stage SHW-1.
  - If EARLY_DONE=1, also leave SHIFT when shamt bits above the current stage are all zero.
  - On exit, load out_data from the working register and go to DONE.
- DONE: hold out_data and out_valid. When out_ready is high at an edge, go to IDLE.
- Op rules:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the captured operand's MSB.
  - ROL: bits leaving the MSB re-enter at the LSB.
- Shift amount 0 returns the operand unchanged. SHIFT still runs at least one stage.
- in_data, in_shamt and in_op are ignored outside the accepting edge. Changing them mid-operation has no effect.
- No new operation is accepted in the cycle the result is consumed. in_ready rises the cycle after the DONE→IDLE edge.
- Reset asserted in any state aborts the operation. The next cycle shows reset values and the operation is discarded.
- Reset has priority over in_valid and out_ready at the same edge.

## Timing
- The accept edge is E0.
- EARLY_DONE=0: latency is fixed at SHW cycles; out_valid rises after edge E_SHW. For WIDTH=32 that is 5 cycles.
- EARLY_DONE=1: latency is max(1, index of highest set shamt bit + 1) cycles.
- The result is held indefinitely under out_ready=0.
- Throughput: one operation per latency+2 cycles with out_ready tied high.
- All outputs are registered; no combinational path from input to output.

## Structure
- Shared package shift_pkg holds:
  - op encodings: OP_SLL, OP_SRL, OP_SRA, OP_ROL;
  - state encoding: S_IDLE, S_SHIFT, S_DONE.
- Sub-module shift_stage (combinational), parameterised by WIDTH:
  - inputs: data, distance (2^stage), op, fill bit;
  - output: shifted word.
  - Instantiated once; the distance is selected by the stage counter.
- The top level holds the FSM, stage counter, operand/shamt/op registers and output register.

## Test plan
- SLL 0x0000FFFF by 16, EARLY_DONE=0 -> out_data=0xFFFF0000; out_valid rises exactly 5 cycles after the accept edge; in_ready=0 throughout.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF. SRL of the same operand by 31 -> 0x00000001. ROL 0x80000001 by 4 -> 0x00000018.
- Hold out_ready=0 for 3 cycles in DONE -> out_data and out_valid stable and in_ready=0. On release, DONE→IDLE, then the next request is accepted one cycle later.
- EARLY_DONE=1:
  - shamt=1 on 0x00000003 SLL -> 0x00000006 after 1 cycle;
  - shamt=0 -> operand returned after 1 cycle;
  - shamt=16 -> 5 cycles.
- Assert reset during SHIFT stage 2 -> next cycle out_valid=0, out_data=0, in_ready=1. A new request then completes correctly.
- Change in_data and in_op while in SHIFT -> result matches the originally captured operation.
